// File: rtl/multicycle_control_if.sv
// Memory request bus between the multicycle control FSM and memory.
// master: control FSM (drives strobes), slave: memory (drives mem_ready).
interface multicycle_control_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_read,
    output mem_write,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_read,
    input  mem_write,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle datapath: fetch/decode/exec/mem/wb.
// Ports: clk, rst (sync, active-high), opcode, mem bus (if), datapath ctl.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 0,
  parameter int WAIT_W       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  opcode,
  multicycle_control_if.master        mem,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        pc_write_cond,
  output logic [1:0]                  pc_source,
  output logic                        alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [2:0]                  aluop,
  output logic                        reg_dst,
  output logic                        mem_to_reg,
  output logic                        reg_write,
  output logic                        halted,
  output logic                        illegal_op,
  output logic                        bus_error
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_R_WB,
    S_EXEC_I, S_I_WB, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ANDI = 4'h2;
  localparam logic [3:0] OP_ORI  = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_J    = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_inc;
  logic                r_bus_err;
  logic                w_mem;
  logic                w_expire;

  assign w_mem = (r_state == S_FETCH) ||
                 (r_state == S_MEM_RD) ||
                 (r_state == S_MEM_WR);

  assign w_wait_inc = r_wait + WAIT_W'(1);

  // Expiry: this stalled cycle would bring the count to the limit.
  assign w_expire = (MEM_WAIT_MAX != 0) && w_mem &&
                    !mem.mem_ready &&
                    (w_wait_inc == WAIT_W'(MEM_WAIT_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_mem && !mem.mem_ready && !w_expire)
        r_wait <= w_wait_inc;
      else
        r_wait <= '0;
      if (w_expire)
        r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    w_next        = S_FETCH;
    mem.mem_req   = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.i_or_d    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = 3'b000;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    halted        = 1'b0;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;
    // Reset forces every output low, aborting any stalled access.
    if (!rst) begin
      bus_error = r_bus_err;
      unique case (r_state)
        S_FETCH: begin
          mem.mem_req  = 1'b1;
          mem.mem_read = 1'b1;
          alu_src_b    = 2'b01;
          if (mem.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_DECODE;
          end else if (w_expire) begin
            w_next = S_HALT;
          end else begin
            w_next = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          unique case (opcode)
            OP_R:    w_next = S_EXEC_R;
            OP_ADDI,
            OP_ANDI,
            OP_ORI:  w_next = S_EXEC_I;
            OP_LW,
            OP_SW:   w_next = S_MEM_ADDR;
            OP_BEQ:  w_next = S_BRANCH;
            OP_J:    w_next = S_JUMP;
            OP_HALT: w_next = S_HALT;
            default: begin
              illegal_op = 1'b1;
              w_next     = S_FETCH;
            end
          endcase
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          aluop     = 3'b100;
          w_next    = S_R_WB;
        end
        S_R_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          unique case (opcode)
            OP_ANDI: aluop = 3'b010;
            OP_ORI:  aluop = 3'b011;
            default: aluop = 3'b000;
          endcase
          w_next = S_I_WB;
        end
        S_I_WB: begin
          reg_write = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          w_next    = (opcode == OP_LW) ? S_MEM_RD
                                        : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem.mem_req  = 1'b1;
          mem.mem_read = 1'b1;
          mem.i_or_d   = 1'b1;
          if (mem.mem_ready)  w_next = S_MEM_WB;
          else if (w_expire)  w_next = S_HALT;
          else                w_next = S_MEM_RD;
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          mem.mem_req   = 1'b1;
          mem.mem_write = 1'b1;
          mem.i_or_d    = 1'b1;
          if (mem.mem_ready)  w_next = S_FETCH;
          else if (w_expire)  w_next = S_HALT;
          else                w_next = S_MEM_WR;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          aluop         = 3'b001;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_HALT: begin
          halted = 1'b1;
          w_next = S_HALT;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule
